// File: rtl/heap_array_search.sv
// heap_array_search: streams one heap array area through the heap read port to find a key or count keys below/above it; the count ops exist only when HEAP_SEARCH_COUNT_EN is defined
module heap_array_search #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea = 4,
  parameter int NHeap = 12
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic [MemoryElementWidth-1:0] array,
  input  logic [MemoryElementWidth-1:0] size,
  input  logic [MemoryElementWidth-1:0] key,
  output logic                          busy,
  output logic                          done,
  output logic [MemoryElementWidth-1:0] result,
  output logic                          heapWrite,
  output logic [NHeap-1:0]              heapAddress,
  output logic [MemoryElementWidth-1:0] heapIn,
  input  logic [MemoryElementWidth-1:0] heapOut
);
  localparam int W = MemoryElementWidth;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state;
  logic [W-1:0] array_q, key_q, n, i;
  logic vld, match, op_ok;
`ifdef HEAP_SEARCH_COUNT_EN
  logic [1:0] op_q;
  logic [W-1:0] acc, acc_next;
  assign op_ok = op != 2'd3;
  assign match = vld && op_q == 2'd0 && heapOut == key_q;
  assign acc_next = acc + W'(vld && ((op_q == 2'd1 && heapOut < key_q) || (op_q == 2'd2 && heapOut > key_q)));
`else
  assign op_ok = op == 2'd0;
  assign match = vld && heapOut == key_q;
`endif
  assign heapWrite = 1'b0;
  assign heapIn = '0;
  // element i of the latched array is addressed only while scanning
  always_comb heapAddress = (state == SCAN) ? NHeap'(32'(array_q) * NArea + 32'(i)) : '0;
  // search sequencer; vld marks that heapOut holds element i-1
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      array_q <= '0;
      key_q <= '0;
      n <= '0;
      i <= '0;
      vld <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
`ifdef HEAP_SEARCH_COUNT_EN
      op_q <= '0;
      acc <= '0;
`endif
    end else begin
      vld <= state == SCAN;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          array_q <= array;
          key_q <= key;
          n <= (size > W'(NArea)) ? W'(NArea) : size;
          i <= '0;
          result <= '0;
          busy <= 1'b1;
`ifdef HEAP_SEARCH_COUNT_EN
          op_q <= op;
          acc <= '0;
`endif
          if (size == '0 || !op_ok) begin
            state <= DONE;
            done <= 1'b1;
          end else state <= SCAN;
        end
        SCAN: begin
          i <= i + W'(1);
`ifdef HEAP_SEARCH_COUNT_EN
          acc <= acc_next;
`endif
          if (match) begin
            result <= i;
            state <= DONE;
            done <= 1'b1;
          end else if (i == n - W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE;
          done <= 1'b1;
`ifdef HEAP_SEARCH_COUNT_EN
          result <= match ? i : acc_next;
`else
          result <= match ? i : '0;
`endif
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_heap_array_search.sv
// tb_heap_array_search: randomized scoreboard bench for heap_array_search against a heap model
module tb_heap_array_search;
  typedef struct {
    int res;
    int lat;
    int base;
    int nissue;
    int t0;
  } exp_t;
`ifdef HEAP_SEARCH_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] op = '0;
  logic [11:0] array = '0, size = '0, key = '0, heapOut = '0;
  logic busy, done, heapWrite;
  logic [11:0] result, heapIn, heapAddress;
  logic [11:0] mem [4096];
  exp_t q[$];
  int cyc = 0, n_tests = 0, n_fail = 0, last_res = 0, k, ea;

  heap_array_search dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .array(array), .size(size), .key(key),
    .busy(busy), .done(done), .result(result), .heapWrite(heapWrite), .heapAddress(heapAddress),
    .heapIn(heapIn), .heapOut(heapOut)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) heapOut <= mem[heapAddress];

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t model(int o, int a, int s, int kk);
    exp_t e;
    int n = s > 4 ? 4 : s;
    e.base = (a * 4) % 4096;
    e.res = 0;
    e.lat = 1;
    e.nissue = 0;
    e.t0 = 0;
    if (n == 0 || o == 3 || (!CNT && o != 0)) return e;
    e.lat = n + 2;
    e.nissue = n;
    for (int j = 0; j < n; j++) begin
      int v = int'(mem[(e.base + j) % 4096]);
      if (o == 0 && v == kk) begin
        e.res = j + 1;
        e.lat = j + 3;
        e.nissue = (j + 2 < n) ? j + 2 : n;
        return e;
      end
      if ((o == 1 && v < kk) || (o == 2 && v > kk)) e.res++;
    end
    return e;
  endfunction

  task automatic check_reset_vals(string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_result"}, int'(result), 0);
    chk({nm, "_addr"}, int'(heapAddress), 0);
    chk({nm, "_write"}, int'(heapWrite), 0);
    chk({nm, "_in"}, int'(heapIn), 0);
  endtask

  task automatic launch(int o, int a, int s, int kk, bit poke);
    exp_t e = model(o, a, s, kk);
    op = 2'(o);
    array = 12'(a);
    size = 12'(s);
    key = 12'(kk);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    e.t0 = cyc - 1;
    q.push_back(e);
    if (poke) begin
      op = 2'd0;
      array = 12'($urandom_range(0, 4095));
      size = 12'd4;
      key = 12'($urandom_range(0, 15));
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic finish_op();
    int c = 0;
    while (q.size() != 0 && c < 30) begin
      @(posedge clock);
      #2;
      c++;
    end
    chk("timeout_queue_left", q.size(), 0);
    q.delete();
  endtask

  task automatic search(int o, int a, int s, int kk, bit poke);
    launch(o, a, s, kk, poke);
    finish_op();
  endtask

  // scoreboard monitor: per-cycle bus checks and result/latency on every done
  always @(negedge clock) if (reset) begin
    chk("heapWrite", int'(heapWrite), 0);
    chk("heapIn", int'(heapIn), 0);
    if (q.size() != 0) begin
      k = cyc - q[0].t0;
      ea = (k <= q[0].nissue) ? (q[0].base + k - 1) % 4096 : 0;
      chk("addr", int'(heapAddress), ea);
      chk("busy", int'(busy), 1);
      if (done) begin
        chk("result", int'(result), q[0].res);
        chk("latency", k, q[0].lat);
        last_res = q[0].res;
        void'(q.pop_front());
      end else if (k >= q[0].lat) begin
        chk("done_missing", int'(done), 1);
        last_res = int'(result);
        void'(q.pop_front());
      end else chk("result_cleared", int'(result), 0);
    end else begin
      chk("idle_addr", int'(heapAddress), 0);
      chk("idle_busy", int'(busy), 0);
      chk("result_hold", int'(result), last_res);
      if (done) chk("spurious_done", int'(done), 0);
    end
  end

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom_range(0, 15));
    mem[0] = 12'd10; mem[1] = 12'd20; mem[2] = 12'd30;
    mem[8] = 12'd1; mem[9] = 12'd2; mem[10] = 12'd3; mem[11] = 12'd20;
    repeat (3) @(posedge clock);
    #2;
    check_reset_vals("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #2;
    search(0, 0, 3, 20, 1'b0);
    search(0, 0, 3, 40, 1'b0);
    search(0, 0, 3, 30, 1'b0);
    search(1, 0, 3, 25, 1'b0);
    search(2, 0, 3, 15, 1'b0);
    search(3, 0, 3, 20, 1'b0);
    search(0, 2, 9, 20, 1'b0);
    search(0, 0, 0, 10, 1'b1);
    search(0, 0, 3, 30, 1'b1);
    search(0, 4095, 4, 7, 1'b0);
    launch(0, 0, 3, 40, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    check_reset_vals("midreset");
    repeat (2) @(posedge clock);
    last_res = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    search(0, 0, 3, 10, 1'b0);
    for (int t = 0; t < 80; t++)
      search($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(1000, 4095) : $urandom_range(0, 40),
             $urandom_range(0, 9), $urandom_range(0, 16), $urandom_range(0, 3) == 0);
    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
